// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit write buffer among several byte producers.
// One requester owns the write-buffer channel at a time. Its bytes pass straight through until
// it has moved MAX_BURST bytes or drops its valid. The next search then starts one past the
// old owner.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   chan_en_i    per-channel enable, only looked at when choosing a new owner
//   req_valid_i  per-channel byte valid
//   req_data_i   per-channel byte; channel i is [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o  per-channel accept (owner only, follows tx_ready_i)
//   tx_data_o    byte to the write buffer
//   tx_valid_o   byte valid to the write buffer
//   tx_ready_i   write buffer can take a byte
//   grant_id_o   current owner index, 0 while idle
//   busy_o       a grant is held
module uart_tx_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            chan_en_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          busy_o
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q;
  logic [IdW-1:0]  owner_q;
  logic [IdW-1:0]  ptr_q;
  logic [CntW-1:0] burst_cnt_q;

  // Round-robin pick: first candidate at or after ptr_q, wrapping.
  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [IdW-1:0]     pick;
  logic [IdW-1:0]     idx;

  always_comb begin
    cand  = req_valid_i & chan_en_i;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IdW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Pass-through of the owner's channel; nothing passes while idle.
  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    if (state_q == StGrant) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner_q == IdW'(i)) begin
          tx_valid_o     = req_valid_i[i];
          tx_data_o      = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
          req_ready_o[i] = tx_ready_i;
        end
      end
    end
  end

  logic           handshake;
  logic           last_beat;
  logic [IdW-1:0] ptr_next;

  assign handshake = tx_valid_o & tx_ready_i;
  assign last_beat = (burst_cnt_q == CntW'(MAX_BURST - 1));
  assign ptr_next  = (owner_q == IdW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            owner_q     <= pick;
            burst_cnt_q <= '0;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          // A dropped valid ends the burst; the old owner becomes lowest priority.
          if (!tx_valid_o || (handshake && last_beat)) begin
            state_q     <= StIdle;
            ptr_q       <= ptr_next;
            owner_q     <= '0;
            burst_cnt_q <= '0;
          end else if (handshake) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant_id_o = owner_q;
  assign busy_o     = (state_q == StGrant);

endmodule
